// File: rtl/arp_pkg.sv
// Shared ARP constants, FSM state type and beat-count helper for the responder.
package arp_pkg;

    localparam logic [15:0] ARP_ETHERTYPE   = 16'h0806;
    localparam logic [15:0] HTYPE_ETH       = 16'h0001;
    localparam logic [15:0] PTYPE_IPV4      = 16'h0800;
    localparam logic [7:0]  HLEN_ETH        = 8'd6;
    localparam logic [7:0]  PLEN_IPV4       = 8'd4;
    localparam logic [15:0] OPER_REQUEST    = 16'd1;
    localparam logic [15:0] OPER_REPLY      = 16'd2;
    localparam int          ARP_FRAME_BYTES = 42;
    localparam int          ARP_FRAME_BITS  = 8 * ARP_FRAME_BYTES;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        RX   = 2'd1,
        TX   = 2'd2
    } arp_state_e;

    // Number of AXIS beats needed to carry one ARP frame on a lane of db bytes.
    function automatic int arp_beats(input int db);
        return (ARP_FRAME_BYTES + db - 1) / db;
    endfunction

endpackage

// File: rtl/arp_tx_serializer.sv
// Turns a 42-byte reply vector (byte 0 in the top bits) into DATA_BYTES-wide AXIS beats.
module arp_tx_serializer
    import arp_pkg::*;
#(
    parameter int DATA_BYTES = 1
) (
    input  logic                      I_CLK,
    input  logic                      I_RESET,
    input  logic                      start_i,
    input  logic [ARP_FRAME_BITS-1:0] reply_i,
    output logic                      m_tvalid_o,
    input  logic                      m_tready_i,
    output logic [8*DATA_BYTES-1:0]   m_tdata_o,
    output logic [DATA_BYTES-1:0]     m_tkeep_o,
    output logic                      m_tlast_o,
    output logic                      done_o
);

    localparam int NBEATS     = arp_beats(DATA_BYTES);
    localparam int LAST_BYTES = ARP_FRAME_BYTES - (NBEATS - 1) * DATA_BYTES;

    logic [ARP_FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [5:0]                beat_q, beat_d;
    logic                      vld_q, vld_d;
    logic                      last;
    logic                      show;

    assign last       = (beat_q == 6'(NBEATS - 1));
    assign show       = vld_q && !I_RESET;
    assign m_tvalid_o = show;
    assign m_tlast_o  = show && last;
    assign done_o     = show && m_tready_i && last;

    // Load on start, then shift one lane-width of bytes out per accepted beat.
    always_comb begin
        shreg_d = shreg_q;
        beat_d  = beat_q;
        vld_d   = vld_q;
        if (start_i) begin
            shreg_d = reply_i;
            beat_d  = '0;
            vld_d   = 1'b1;
        end else if (vld_q && m_tready_i) begin
            shreg_d = shreg_q << (8 * DATA_BYTES);
            if (last) begin
                vld_d  = 1'b0;
                beat_d = '0;
            end else begin
                beat_d = beat_q + 6'd1;
            end
        end
    end

    // Map the head of the shift register onto the lanes; bytes past the frame are zero.
    always_comb begin
        m_tdata_o = '0;
        m_tkeep_o = '0;
        for (int j = 0; j < DATA_BYTES; j++) begin
            if (show) begin
                m_tdata_o[8*j +: 8] = shreg_q[ARP_FRAME_BITS-1-8*j -: 8];
                m_tkeep_o[j]        = last ? (j < LAST_BYTES) : 1'b1;
            end
        end
    end

    // Reset abandons any reply mid-flight and clears the visible data.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            shreg_q <= '0;
            beat_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            beat_q  <= beat_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: rtl/arp_responder_mx.sv
// ARP responder: captures Ethernet/ARP requests from AXIS, answers those that
// target a local IPv4 address with a 42-byte reply, and counts replies/drops.
module arp_responder_mx
    import arp_pkg::*;
#(
    parameter int                      DATA_BYTES = 1,
    parameter int                      N_ADDR     = 2,
    parameter logic [N_ADDR-1:0][31:0] IPV4_TABLE = '0,
    parameter logic [N_ADDR-1:0][47:0] MAC_TABLE  = '0
) (
    input  logic                    I_CLK,
    input  logic                    I_RESET,
    input  logic                    S_AXIS_TVALID,
    output logic                    S_AXIS_TREADY,
    input  logic [8*DATA_BYTES-1:0] S_AXIS_TDATA,
    input  logic [DATA_BYTES-1:0]   S_AXIS_TKEEP,
    input  logic                    S_AXIS_TLAST,
    input  logic                    S_AXIS_TUSER,
    output logic                    M_AXIS_TVALID,
    input  logic                    M_AXIS_TREADY,
    output logic [8*DATA_BYTES-1:0] M_AXIS_TDATA,
    output logic [DATA_BYTES-1:0]   M_AXIS_TKEEP,
    output logic                    M_AXIS_TLAST,
    output logic [15:0]             O_REPLY_COUNT,
    output logic [15:0]             O_DROP_COUNT
);

    // Byte counter only needs to prove ">= 42"; it saturates well above that.
    localparam logic [7:0] CNT_SAT = 8'd64;

    arp_state_e                state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic [15:0]               drop_q, drop_d;
    logic [15:0]               reply_q, reply_d;
    logic [41:0][7:0]          frm_q, frm_d;

    logic                      in_hs;
    logic                      rx_beat;
    logic [7:0]                pop;
    logic [7:0]                byte_total;
    logic                      hdr_ok;
    logic                      hit;
    logic                      frame_ok;
    logic                      start;
    logic                      tx_done;
    logic [31:0]               tpa, spa, sel_ip;
    logic [47:0]               sha, sel_mac;
    logic [ARP_FRAME_BITS-1:0] reply_vec;

    assign S_AXIS_TREADY = !I_RESET && (state_q != TX);
    assign in_hs         = S_AXIS_TVALID && S_AXIS_TREADY;
    assign rx_beat       = in_hs && (state_q == RX);
    assign O_REPLY_COUNT = I_RESET ? 16'd0 : reply_q;
    assign O_DROP_COUNT  = I_RESET ? 16'd0 : drop_q;

    // Count enabled bytes in the current beat (TKEEP is contiguous).
    always_comb begin
        pop = '0;
        for (int j = 0; j < DATA_BYTES; j++) begin
            pop = pop + {7'd0, S_AXIS_TKEEP[j]};
        end
    end

    assign byte_total = cnt_q + pop;

    // Place each enabled lane at its absolute frame offset; bytes past 41 are ignored.
    always_comb begin
        logic [7:0] idx;
        frm_d = frm_q;
        idx   = '0;
        if (rx_beat) begin
            for (int j = 0; j < DATA_BYTES; j++) begin
                idx = cnt_q + 8'(j);
                if (S_AXIS_TKEEP[j] && (idx < 8'(ARP_FRAME_BYTES))) begin
                    frm_d[idx[5:0]] = S_AXIS_TDATA[8*j +: 8];
                end
            end
        end
    end

    assign sha = {frm_d[22], frm_d[23], frm_d[24], frm_d[25], frm_d[26], frm_d[27]};
    assign spa = {frm_d[28], frm_d[29], frm_d[30], frm_d[31]};
    assign tpa = {frm_d[38], frm_d[39], frm_d[40], frm_d[41]};

    assign hdr_ok = ({frm_d[12], frm_d[13]} == ARP_ETHERTYPE) &&
                    ({frm_d[14], frm_d[15]} == HTYPE_ETH)     &&
                    ({frm_d[16], frm_d[17]} == PTYPE_IPV4)    &&
                    (frm_d[18] == HLEN_ETH)                   &&
                    (frm_d[19] == PLEN_IPV4)                  &&
                    ({frm_d[20], frm_d[21]} == OPER_REQUEST);

    // Search the table from the top down so the lowest matching index wins.
    always_comb begin
        hit     = 1'b0;
        sel_ip  = '0;
        sel_mac = '0;
        for (int i = N_ADDR - 1; i >= 0; i--) begin
            if (IPV4_TABLE[i] == tpa) begin
                hit     = 1'b1;
                sel_ip  = IPV4_TABLE[i];
                sel_mac = MAC_TABLE[i];
            end
        end
    end

    assign frame_ok = (byte_total >= 8'(ARP_FRAME_BYTES)) && !(err_q || S_AXIS_TUSER) &&
                      hdr_ok && hit;

    assign reply_vec = {sha, sel_mac, ARP_ETHERTYPE, HTYPE_ETH, PTYPE_IPV4, HLEN_ETH,
                        PLEN_IPV4, OPER_REPLY, sel_mac, sel_ip, sha, spa};

    // Frame sequencing: resync after reset, judge each frame at TLAST, hold input during a reply.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        drop_d  = drop_q;
        reply_d = reply_q;
        start   = 1'b0;
        case (state_q)
            SYNC: begin
                if (in_hs && S_AXIS_TLAST) begin
                    state_d = RX;
                end
            end
            RX: begin
                if (in_hs) begin
                    if (S_AXIS_TLAST) begin
                        cnt_d = '0;
                        err_d = 1'b0;
                        if (frame_ok) begin
                            state_d = TX;
                            start   = 1'b1;
                        end else begin
                            drop_d = drop_q + 16'd1;
                        end
                    end else begin
                        cnt_d = (byte_total > CNT_SAT) ? CNT_SAT : byte_total;
                        err_d = err_q || S_AXIS_TUSER;
                    end
                end
            end
            TX: begin
                if (tx_done) begin
                    state_d = RX;
                    reply_d = reply_q + 16'd1;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    // Control state and counters; reset returns to SYNC so a partial frame is drained.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q <= SYNC;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            drop_q  <= '0;
            reply_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            reply_q <= reply_d;
        end
    end

    // Captured frame bytes; always rewritten in full before a frame can be accepted.
    always_ff @(posedge I_CLK) begin
        frm_q <= frm_d;
    end

    arp_tx_serializer #(
        .DATA_BYTES (DATA_BYTES)
    ) u_tx (
        .I_CLK      (I_CLK),
        .I_RESET    (I_RESET),
        .start_i    (start),
        .reply_i    (reply_vec),
        .m_tvalid_o (M_AXIS_TVALID),
        .m_tready_i (M_AXIS_TREADY),
        .m_tdata_o  (M_AXIS_TDATA),
        .m_tkeep_o  (M_AXIS_TKEEP),
        .m_tlast_o  (M_AXIS_TLAST),
        .done_o     (tx_done)
    );

endmodule

// File: tb/tb_arp_responder_mx.sv
// Directed bench for arp_responder_mx: a 4-byte-lane instance and a 1-byte-lane instance.
module tb_arp_responder_mx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0][31:0] IPT  = {32'h0A000002, 32'h0A000001};
    localparam logic [1:0][47:0] MACT = {48'h02AABBCCDD02, 48'h02AABBCCDD01};

    localparam logic [335:0] EXP1 = 336'h020000000064_02AABBCCDD02_0806_0001_0800_06_04_0002_02AABBCCDD02_0A000002_020000000064_0A000064;
    localparam logic [335:0] EXP0 = 336'h020000000064_02AABBCCDD01_0806_0001_0800_06_04_0002_02AABBCCDD01_0A000001_020000000064_0A000064;

    logic        rst4, s4_tvalid, s4_tready, s4_tlast, s4_tuser;
    logic [31:0] s4_tdata;
    logic [3:0]  s4_tkeep;
    logic        m4_tvalid, m4_tready, m4_tlast;
    logic [31:0] m4_tdata;
    logic [3:0]  m4_tkeep;
    logic [15:0] rc4, dc4;

    logic        rst1, s1_tvalid, s1_tready, s1_tlast, s1_tuser;
    logic [7:0]  s1_tdata;
    logic [0:0]  s1_tkeep;
    logic        m1_tvalid, m1_tready, m1_tlast;
    logic [7:0]  m1_tdata;
    logic [0:0]  m1_tkeep;
    logic [15:0] rc1, dc1;

    arp_responder_mx #(.DATA_BYTES(4), .N_ADDR(2), .IPV4_TABLE(IPT), .MAC_TABLE(MACT)) dut4 (
        .I_CLK(clk), .I_RESET(rst4),
        .S_AXIS_TVALID(s4_tvalid), .S_AXIS_TREADY(s4_tready), .S_AXIS_TDATA(s4_tdata),
        .S_AXIS_TKEEP(s4_tkeep), .S_AXIS_TLAST(s4_tlast), .S_AXIS_TUSER(s4_tuser),
        .M_AXIS_TVALID(m4_tvalid), .M_AXIS_TREADY(m4_tready), .M_AXIS_TDATA(m4_tdata),
        .M_AXIS_TKEEP(m4_tkeep), .M_AXIS_TLAST(m4_tlast),
        .O_REPLY_COUNT(rc4), .O_DROP_COUNT(dc4)
    );

    arp_responder_mx #(.DATA_BYTES(1), .N_ADDR(2), .IPV4_TABLE(IPT), .MAC_TABLE(MACT)) dut1 (
        .I_CLK(clk), .I_RESET(rst1),
        .S_AXIS_TVALID(s1_tvalid), .S_AXIS_TREADY(s1_tready), .S_AXIS_TDATA(s1_tdata),
        .S_AXIS_TKEEP(s1_tkeep), .S_AXIS_TLAST(s1_tlast), .S_AXIS_TUSER(s1_tuser),
        .M_AXIS_TVALID(m1_tvalid), .M_AXIS_TREADY(m1_tready), .M_AXIS_TDATA(m1_tdata),
        .M_AXIS_TKEEP(m1_tkeep), .M_AXIS_TLAST(m1_tlast),
        .O_REPLY_COUNT(rc1), .O_DROP_COUNT(dc1)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0]   req [0:63];
    logic [335:0] rx_vec;
    logic [335:0] ref_vec;
    int           rx_beats;
    logic [3:0]   rx_last_keep;
    int           rx_keep_err, rx_pad_err, rx_stab_err, rx_sready_err;
    bit           rx_timeout;
    int           seen;

    task automatic check(input string tag, input logic [335:0] obs, input logic [335:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_req(input logic [31:0] tpa, input int len);
        logic [335:0] hdr;
        hdr = {48'hFFFFFFFFFFFF, 48'h020000000064, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
               16'h0001, 48'h020000000064, 32'h0A000064, 48'h000000000000, tpa};
        for (int i = 0; i < 64; i++) req[i] = 8'h00;
        for (int i = 0; i < 42; i++) req[i] = hdr[335-8*i -: 8];
        for (int i = 42; i < len; i++) req[i] = 8'hA5;
    endtask

    // Drive bytes [first, n) as beats; TLAST on the final beat if with_last; TUSER on beat tuser_beat.
    task automatic send_frame(input int sel, input int first, input int n, input bit with_last,
                              input int tuser_beat);
        int db, b, beat, cyc;
        logic [31:0] d;
        logic [3:0] k;
        bit lst, hs;
        db = (sel == 1) ? 1 : 4;
        b = first;
        beat = 0;
        while (b < n) begin
            d = '0;
            k = '0;
            for (int j = 0; j < db; j++) begin
                if (b + j < n) begin
                    d[8*j +: 8] = req[b+j];
                    k[j] = 1'b1;
                end
            end
            lst = with_last && (b + db >= n);
            if (sel == 1) begin
                s1_tvalid = 1'b1; s1_tdata = d[7:0]; s1_tkeep = k[0:0];
                s1_tlast = lst; s1_tuser = (beat == tuser_beat);
            end else begin
                s4_tvalid = 1'b1; s4_tdata = d; s4_tkeep = k;
                s4_tlast = lst; s4_tuser = (beat == tuser_beat);
            end
            hs = 1'b0;
            cyc = 0;
            while (!hs && cyc < 100) begin
                @(negedge clk);
                hs = (sel == 1) ? s1_tready : s4_tready;
                @(posedge clk);
                #1;
                cyc++;
            end
            if (!hs) begin
                check("send_timeout", 336'(hs), 336'(1));
                break;
            end
            b += db;
            beat++;
        end
        s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tuser = 1'b0;
        s4_tvalid = 1'b0; s4_tlast = 1'b0; s4_tuser = 1'b0;
    endtask

    // Collect one reply; with stall, M_AXIS_TREADY is low on every other cycle.
    task automatic recv(input int sel, input bit stall);
        int db, bi, cyc;
        bit done, held;
        logic v, l, sr, rdy;
        logic [31:0] d, pd;
        logic [3:0] k, pk, full;
        logic pl;
        db = (sel == 1) ? 1 : 4;
        full = (sel == 1) ? 4'h1 : 4'hF;
        rx_vec = '0; rx_beats = 0; rx_last_keep = '0;
        rx_keep_err = 0; rx_pad_err = 0; rx_stab_err = 0; rx_sready_err = 0;
        bi = 0; cyc = 0; done = 1'b0; held = 1'b0;
        pd = '0; pk = '0; pl = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            rdy = stall ? (cyc % 2 == 1) : 1'b1;
            if (sel == 1) begin
                m1_tready = rdy;
                v = m1_tvalid; d = {24'd0, m1_tdata}; k = {3'd0, m1_tkeep}; l = m1_tlast; sr = s1_tready;
            end else begin
                m4_tready = rdy;
                v = m4_tvalid; d = m4_tdata; k = m4_tkeep; l = m4_tlast; sr = s4_tready;
            end
            if (held && (!v || d !== pd || k !== pk || l !== pl)) rx_stab_err++;
            if (sr) rx_sready_err++;
            if (v && rdy) begin
                for (int j = 0; j < db; j++) begin
                    if (k[j] && bi < 42) begin
                        rx_vec[335-8*bi -: 8] = d[8*j +: 8];
                        bi++;
                    end else if (d[8*j +: 8] !== 8'h00) begin
                        rx_pad_err++;
                    end
                end
                rx_beats++;
                if (l) begin
                    done = 1'b1;
                    rx_last_keep = k;
                end else if (k !== full) begin
                    rx_keep_err++;
                end
                held = 1'b0;
            end else begin
                held = v;
                pd = d; pk = k; pl = l;
            end
            @(posedge clk);
            cyc++;
        end
        #1;
        m1_tready = 1'b1;
        m4_tready = 1'b1;
        rx_timeout = !done;
    endtask

    task automatic idle(input int sel, input int n, output int vs);
        vs = 0;
        repeat (n) begin
            @(negedge clk);
            if ((sel == 1) ? m1_tvalid : m4_tvalid) vs++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst4 = 1'b1; rst1 = 1'b1;
        s4_tvalid = 1'b0; s4_tdata = '0; s4_tkeep = '0; s4_tlast = 1'b0; s4_tuser = 1'b0;
        s1_tvalid = 1'b0; s1_tdata = '0; s1_tkeep = '0; s1_tlast = 1'b0; s1_tuser = 1'b0;
        m4_tready = 1'b1; m1_tready = 1'b1;

        // Reset state, 4-byte instance
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", 336'(s4_tready), 336'(0));
        check("rst_m_outputs", 336'({m4_tvalid, m4_tlast, m4_tkeep, m4_tdata}), 336'(0));
        check("rst_counts", 336'({rc4, dc4}), 336'(0));
        rst4 = 1'b0;
        @(posedge clk);
        #1;
        check("sync_s_tready", 336'(s4_tready), 336'(1));

        // Alignment frame consumed in SYNC, never counted as a drop
        build_req(32'h0A000002, 42);
        send_frame(0, 0, 8, 1'b1, -1);
        check("sync_no_drop", 336'(dc4), 336'(0));

        // Valid request for entry 1
        send_frame(0, 0, 42, 1'b1, -1);
        check("tvalid_next_cycle", 336'(m4_tvalid), 336'(1));
        check("s_tready_low_in_tx", 336'(s4_tready), 336'(0));
        recv(0, 1'b0);
        check("r1_timeout", 336'(rx_timeout), 336'(0));
        check("r1_beats", 336'(rx_beats), 336'(11));
        check("r1_last_keep", 336'(rx_last_keep), 336'(4'h3));
        check("r1_keep_full", 336'(rx_keep_err), 336'(0));
        check("r1_pad_zero", 336'(rx_pad_err), 336'(0));
        check("r1_dst_mac", 336'(rx_vec[335 -: 48]), 336'(48'h020000000064));
        check("r1_src_mac", 336'(rx_vec[287 -: 48]), 336'(48'h02AABBCCDD02));
        check("r1_oper", 336'(rx_vec[175 -: 16]), 336'(16'h0002));
        check("r1_sha", 336'(rx_vec[159 -: 48]), 336'(48'h02AABBCCDD02));
        check("r1_spa", 336'(rx_vec[111 -: 32]), 336'(32'h0A000002));
        check("r1_tpa", 336'(rx_vec[31 -: 32]), 336'(32'h0A000064));
        check("r1_frame", rx_vec, EXP1);
        check("r1_reply_count", 336'(rc4), 336'(1));
        ref_vec = rx_vec;

        // Unknown TPA is dropped
        build_req(32'h0A000099, 42);
        send_frame(0, 0, 42, 1'b1, -1);
        idle(0, 10, seen);
        check("miss_no_tvalid", 336'(seen), 336'(0));
        check("miss_drop_count", 336'(dc4), 336'(1));

        // Same valid request with output backpressure on alternate cycles
        build_req(32'h0A000002, 42);
        send_frame(0, 0, 42, 1'b1, -1);
        recv(0, 1'b1);
        check("stall_timeout", 336'(rx_timeout), 336'(0));
        check("stall_beats", 336'(rx_beats), 336'(11));
        check("stall_same_frame", rx_vec, ref_vec);
        check("stall_hold_stable", 336'(rx_stab_err), 336'(0));
        check("stall_s_tready_low", 336'(rx_sready_err), 336'(0));
        check("stall_reply_count", 336'(rc4), 336'(2));

        // 40-byte frame, then a valid frame carrying TUSER on its third beat
        send_frame(0, 0, 40, 1'b1, -1);
        send_frame(0, 0, 42, 1'b1, 2);
        idle(0, 10, seen);
        check("short_err_no_tvalid", 336'(seen), 336'(0));
        check("short_err_drops", 336'(dc4), 336'(3));
        check("short_err_replies", 336'(rc4), 336'(2));

        // Reset in the middle of a request at byte 20
        send_frame(0, 0, 20, 1'b0, -1);
        rst4 = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_s_tready", 336'(s4_tready), 336'(0));
        check("midrst_m_outputs", 336'({m4_tvalid, m4_tlast, m4_tkeep, m4_tdata}), 336'(0));
        check("midrst_counts", 336'({rc4, dc4}), 336'(0));
        rst4 = 1'b0;
        @(posedge clk);
        #1;
        send_frame(0, 20, 42, 1'b1, -1);
        idle(0, 4, seen);
        check("drain_no_tvalid", 336'(seen), 336'(0));
        check("drain_no_drop", 336'(dc4), 336'(0));
        send_frame(0, 0, 42, 1'b1, -1);
        check("post_rst_tvalid", 336'(m4_tvalid), 336'(1));
        recv(0, 1'b0);
        check("post_rst_frame", rx_vec, EXP1);
        check("post_rst_reply_count", 336'(rc4), 336'(1));

        // 1-byte instance: reset, align, then a 60-byte padded request for entry 0
        check("db1_rst_outputs", 336'({s1_tready, m1_tvalid, m1_tlast, m1_tkeep, m1_tdata}), 336'(0));
        rst1 = 1'b0;
        @(posedge clk);
        #1;
        build_req(32'h0A000001, 60);
        send_frame(1, 0, 8, 1'b1, -1);
        send_frame(1, 0, 60, 1'b1, -1);
        check("db1_tvalid_next_cycle", 336'(m1_tvalid), 336'(1));
        recv(1, 1'b0);
        check("db1_timeout", 336'(rx_timeout), 336'(0));
        check("db1_beats", 336'(rx_beats), 336'(42));
        check("db1_last_keep", 336'(rx_last_keep), 336'(1));
        check("db1_keep_each", 336'(rx_keep_err), 336'(0));
        check("db1_frame", rx_vec, EXP0);
        check("db1_counts", 336'({rc1, dc1}), 336'({16'd1, 16'd0}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arp_responder_mx.md
ARP_RESPONDER_MX -- requirements
Module: arp_responder_mx

Interface
REQ-001 Parameter DATA_BYTES, default 1, AXIS lane width in bytes; legal values 1, 2, 4, 8.
REQ-002 Parameter N_ADDR, default 2, number of local IPv4/MAC entries answered.
REQ-003 Parameter IPV4_TABLE, default all-zero, packed [N_ADDR][32] local IPv4 addresses.
REQ-004 Parameter MAC_TABLE, default all-zero, packed [N_ADDR][48] local MACs, index-aligned with IPV4_TABLE.
REQ-005 Ports, clock and reset first:
- I_CLK  in  1  clock; all logic on rising edge
- I_RESET  in  1  synchronous, active-high reset
- S_AXIS_TVALID  in  1  input beat valid
- S_AXIS_TREADY  out  1  input beat accepted
- S_AXIS_TDATA  in  8*DATA_BYTES  frame bytes; byte 0 on [7:0]
- S_AXIS_TKEEP  in  DATA_BYTES  byte enables; all ones except on the TLAST beat, which is contiguous from bit 0
- S_AXIS_TLAST  in  1  last beat of frame
- S_AXIS_TUSER  in  1  frame error flag, sampled on any beat
- M_AXIS_TVALID / TREADY / TDATA / TKEEP / TLAST  out/in/out/out/out  1/1/8*DATA_BYTES/DATA_BYTES/1  reply stream, same byte order
- O_REPLY_COUNT  out  16  replies sent
- O_DROP_COUNT  out  16  frames dropped

Function
REQ-006 Frame layout, multi-byte fields MSB first:
- 0-5 dst MAC; 6-11 src MAC; 12-13 EtherType
- 14-15 HTYPE; 16-17 PTYPE; 18 HLEN; 19 PLEN; 20-21 OPER
- 22-27 SHA; 28-31 SPA; 32-37 THA; 38-41 TPA
REQ-007 An input frame is valid iff all of the following hold; anything else is a drop:
- at least 42 bytes
- EtherType 0x0806, HTYPE 1, PTYPE 0x0800, HLEN 6, PLEN 4, OPER 1
- TUSER never high during the frame
- TPA equals some IPV4_TABLE entry
REQ-008 Bytes beyond 41, e.g. padding to 60, are accepted and ignored; dst MAC and THA are not checked.
REQ-009 If TPA matches several entries, the lowest index k is selected.
REQ-010 State machine: SYNC, RX, TX.
- SYNC: TREADY=1; discard beats until a TLAST handshake, then go to RX.
- RX: TREADY=1; capture bytes; on a TLAST handshake go to TX if the frame is valid, else stay in RX and increment O_DROP_COUNT.
- TX: TREADY=0; serialise the reply; after the TLAST handshake go to RX.
REQ-011 Reply content, 42 bytes:
- dst MAC = request SHA; src MAC = MAC_TABLE[k]
- EtherType 0x0806, HTYPE 1, PTYPE 0x0800, HLEN 6, PLEN 4, OPER 2
- SHA = MAC_TABLE[k]; SPA = IPV4_TABLE[k]
- THA = request SHA; TPA = request SPA
REQ-012 The reply is ceil(42/DATA_BYTES) beats. The final beat has TLAST=1 and TKEEP covering the remaining bytes (42 mod DATA_BYTES, or all bytes if zero). Unused data bytes are 0.
REQ-013 M_AXIS_TVALID rises on the cycle after the input TLAST handshake of a valid frame.
REQ-014 Output handshake rules:
- Once TVALID is high, TDATA/TKEEP/TLAST hold stable until TREADY is sampled high.
- TVALID does not drop before the TLAST handshake.
- Back-to-back beats follow when TREADY stays high.
REQ-015 O_REPLY_COUNT increments on the reply TLAST handshake. Both counters wrap modulo 2^16.
REQ-016 An input TLAST on a beat shorter than 42 cumulative bytes produces a drop, not a reply.

Reset
REQ-017 While I_RESET=1:
- S_AXIS_TREADY=0
- M_AXIS_TVALID, TDATA, TKEEP, TLAST = 0
- both counters = 0
- state = SYNC
REQ-018 Reset during RX or TX aborts the frame. Any reply in progress is abandoned without TLAST, and the input remainder is drained in SYNC.

Structure
REQ-019 Shared package arp_pkg holds:
- ARP_ETHERTYPE=0x0806, HTYPE_ETH=1, PTYPE_IPV4=0x0800, HLEN_ETH=6, PLEN_IPV4=4
- OPER_REQUEST=1, OPER_REPLY=2, ARP_FRAME_BYTES=42
- the state enum {SYNC, RX, TX}
REQ-020 One sub-module, arp_tx_serializer. It takes a 336-bit reply vector plus a start pulse and emits DATA_BYTES-wide AXIS beats with TKEEP/TLAST.

Verification
REQ-021 Setup: DATA_BYTES=4; entry0 0x0A000001/0x02AABBCCDD01; entry1 0x0A000002/0x02AABBCCDD02. Request SHA 0x020000000064, SPA 0x0A000064, TPA 0x0A000002 -> 11 beats.
- beat 11: TKEEP=0x3, TLAST=1
- dst MAC 0x020000000064; src MAC and SHA 0x02AABBCCDD02
- OPER 2; SPA 0x0A000002; TPA 0x0A000064
- O_REPLY_COUNT=1
REQ-022 Same request with TPA 0x0A000099 -> no M_AXIS_TVALID; O_DROP_COUNT=1.
REQ-023 60-byte padded request for entry0, DATA_BYTES=1 -> 42 beats, TKEEP=1 each, TLAST on beat 42, reply holds entry0 addresses.
REQ-024 M_AXIS_TREADY low on alternate cycles -> beat contents identical to the unstalled run; S_AXIS_TREADY=0 from the first reply beat to the TLAST handshake.
REQ-025 40-byte frame with TLAST, and a valid frame with TUSER=1 on beat 3 -> two drops, O_DROP_COUNT=2, no reply.
REQ-026 I_RESET pulsed mid-request at byte 20 -> outputs zero; the rest is drained; the next valid request is answered normally.
